switch_led_panel: RTL and testbench
===================================

// Module: switch_led_panel
// PURPOSE
//  Board-level demo block driven by switches, LEDs and one 7-segment digit. Bundles three sub-functions:
//  - a rotating "running light" on the upper LEDs;
//  - an 8-to-3 priority encoder whose result appears on the low LEDs;
//  - a hex-to-7-segment decoder that shows the encoder result on seg0.
//  It sits in the top-level wrapper between the board I/O pins and the VGA/PS2 logic.
// PARAMETERS
//  LED_W     12         width of running-light field (maps to led[15:4])
//  TICK_DIV  5_000_000  clk cycles per light rotation step (>=2)
// PORTS
//  clk   in   1   single system clock, rising edge
//  rst   in   1   asynchronous, active-high reset
//  sw    in   10  sw[7:0] = encoder input x; sw[8] = encoder enable; sw[9] = display enable
//  led   out  16  led[15:4] = running light; led[3] = 0; led[2:0] = encoder result y
//  hex   out  8   seg0 pattern, active-low: bit0=a … bit6=g, bit7=dp
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain: clk. Reset is asynchronous, active-high (rst).
//  Running light (only state in the block)
//  - State: tick counter cnt (ceil(log2(TICK_DIV)) bits) and an LED_W-bit register lr.
//  - Reset: cnt=0 and lr=1 (only bit0 lit), so led[15:4]=12'h001 while rst=1.
//  - Counting: cnt increments every clk.
//  - Rotation step: on the edge where cnt==TICK_DIV-1, cnt wraps to 0 and lr rotates left: lr <= {lr[LED_W-2:0], lr[LED_W-1]}.
//  - Timing: the first rotation lands TICK_DIV edges after reset release. After the step from MSB the light returns to bit0 (wrap-around).
//  - Exactly one bit of lr is set at all times.
//  - Asserting rst mid-count restores the reset state immediately.
//  Priority encoder (combinational, zero latency)
//  - y = index of the highest set bit of sw[7:0].
//  - y = 0 when sw[8]=0 or sw[7:0]==0, so y=0 is ambiguous between "bit0" and "none".
//  - Not affected by rst.
//  7-segment decoder (combinational, zero latency)
//  - Input nibble = {1'b0, y}. Decoder supports the full 0..F range.
//  - When sw[9]=0: hex = 8'hFF (all segments off).
//  - When sw[9]=1, active-low codes (dp always off, bit7=1):
//    0 C0   1 F9   2 A4   3 B0   4 99   5 92   6 82   7 F8
//    8 80   9 90   A 88   b 83   C C6   d A1   E 86   F 8E
//  - Not affected by rst.
//  Other outputs
//  - led[3] is constant 0.
//  - Outputs have no X under any input combination.
// STRUCTURE
//  - Shared package: the SEG7_* 16-entry active-low code table and the SEG7_BLANK=8'hFF constant.
//  - Sub-modules: light_runner (counter+rotator, the only sequential part).
//  - Encoder and decoder are functions/always_comb blocks in this file.
// TESTING
//  Light tests use TICK_DIV=4.
//  1. rst=1 -> led[15:4]=001. Release, run 4 clk -> 002; run 44 more clk (12 steps total) -> back to 001.
//  2. Pulse rst while lr=010 and cnt=2 -> led[15:4]=001 immediately. Next step occurs 4 clk after release.
//  3. sw[8]=1, sw[7:0] = 01/02/80/A5/00 -> led[2:0] = 0/1/7/7/0.
//     Then sw[8]=0 with sw[7:0]=80 -> 0.
//  4. sw[9]=1, force y=0..7 via one-hot sw[7:0] -> hex = C0,F9,A4,B0,99,92,82,F8.
//     Then sw[9]=0 -> hex=FF.
//  5. Decoder unit check for nibbles 8..F -> 80,90,88,83,C6,A1,86,8E.
//     Random sw for 1000 clk: led[3]==0, hex[7]==1, exactly one led[15:4] bit set.

Source files
------------

// File: rtl/switch_led_panel_pkg.sv
// Shared constants for the switch/LED demo panel: active-low 7-segment code table
// and the helper that maps a nibble onto it.
package switch_led_panel_pkg;

    localparam logic [7:0] SEG7_BLANK = 8'hFF;

    localparam logic [7:0] SEG7_0 = 8'hC0;
    localparam logic [7:0] SEG7_1 = 8'hF9;
    localparam logic [7:0] SEG7_2 = 8'hA4;
    localparam logic [7:0] SEG7_3 = 8'hB0;
    localparam logic [7:0] SEG7_4 = 8'h99;
    localparam logic [7:0] SEG7_5 = 8'h92;
    localparam logic [7:0] SEG7_6 = 8'h82;
    localparam logic [7:0] SEG7_7 = 8'hF8;
    localparam logic [7:0] SEG7_8 = 8'h80;
    localparam logic [7:0] SEG7_9 = 8'h90;
    localparam logic [7:0] SEG7_A = 8'h88;
    localparam logic [7:0] SEG7_B = 8'h83;
    localparam logic [7:0] SEG7_C = 8'hC6;
    localparam logic [7:0] SEG7_D = 8'hA1;
    localparam logic [7:0] SEG7_E = 8'h86;
    localparam logic [7:0] SEG7_F = 8'h8E;

    // bit0=a .. bit6=g, bit7=dp; decimal point is always off.
    function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
        logic [7:0] code;
        code = SEG7_BLANK;
        case (nib)
            4'h0: code = SEG7_0;
            4'h1: code = SEG7_1;
            4'h2: code = SEG7_2;
            4'h3: code = SEG7_3;
            4'h4: code = SEG7_4;
            4'h5: code = SEG7_5;
            4'h6: code = SEG7_6;
            4'h7: code = SEG7_7;
            4'h8: code = SEG7_8;
            4'h9: code = SEG7_9;
            4'hA: code = SEG7_A;
            4'hB: code = SEG7_B;
            4'hC: code = SEG7_C;
            4'hD: code = SEG7_D;
            4'hE: code = SEG7_E;
            4'hF: code = SEG7_F;
            default: code = SEG7_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/switch_led_panel_light_runner.sv
// Running light: a one-hot register that rotates left once every TICK_DIV clocks.
module light_runner
    import switch_led_panel_pkg::*;
#(
    parameter int unsigned LED_W    = 12,
    parameter int unsigned TICK_DIV = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [LED_W-1:0] lr_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LED_W-1:0] lr_q, lr_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        lr_d  = lr_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            lr_d  = {lr_q[LED_W-2:0], lr_q[LED_W-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            lr_q  <= LED_W'(1);
        end else begin
            cnt_q <= cnt_d;
            lr_q  <= lr_d;
        end
    end

    assign lr_o = lr_q;

endmodule

// File: rtl/switch_led_panel.sv
// Board demo block: running light on led[15:4], 8-to-3 priority encoder on led[2:0],
// and the encoder result shown on the 7-segment digit.
module switch_led_panel
    import switch_led_panel_pkg::*;
#(
    parameter int unsigned LED_W    = 12,
    parameter int unsigned TICK_DIV = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sw,
    output logic [15:0] led,
    output logic [7:0]  hex
);

    logic [LED_W-1:0] lr;
    logic [2:0]       y;

    // y=0 covers both "bit0 set" and "nothing set / disabled".
    function automatic logic [2:0] prio_enc8(input logic [7:0] x, input logic en);
        logic [2:0] idx;
        idx = 3'd0;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (x[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    light_runner #(
        .LED_W    (LED_W),
        .TICK_DIV (TICK_DIV)
    ) u_light_runner (
        .clk  (clk),
        .rst  (rst),
        .lr_o (lr)
    );

    always_comb begin
        y   = prio_enc8(sw[7:0], sw[8]);
        hex = SEG7_BLANK;
        if (sw[9]) hex = seg7_decode({1'b0, y});
    end

    assign led = {lr, 1'b0, y};

endmodule

// File: tb/tb_switch_led_panel.sv
// Scoreboard bench for switch_led_panel with a short rotation period (TICK_DIV=4).
module tb_switch_led_panel;
    import switch_led_panel_pkg::*;

    localparam int unsigned TICK_DIV = 4;

    localparam int unsigned K_LIGHT  = 0;
    localparam int unsigned K_Y      = 1;
    localparam int unsigned K_HEX    = 2;
    localparam int unsigned K_ONEHOT = 3;
    localparam int unsigned K_LED3   = 4;
    localparam int unsigned K_DP     = 5;

    localparam logic [7:0] HEX_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct {
        string       tag;
        int unsigned kind;
        logic [15:0] exp;
    } sb_item_t;

    logic        clk;
    logic        rst;
    logic [9:0]  sw;
    logic [15:0] led;
    logic [7:0]  hex;

    sb_item_t sb_q[$];
    int n_cmp;
    int n_err;

    switch_led_panel #(
        .LED_W    (12),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .led (led),
        .hex (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int unsigned kind, input logic [15:0] exp);
        sb_item_t it;
        it.tag  = tag;
        it.kind = kind;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_drain();
        sb_item_t    it;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.kind)
                K_LIGHT:  obs = {4'h0, led[15:4]};
                K_Y:      obs = {13'h0, led[2:0]};
                K_HEX:    obs = {8'h0, hex};
                K_ONEHOT: obs = 16'($countones(led[15:4]));
                K_LED3:   obs = {15'h0, led[3]};
                default:  obs = {15'h0, hex[7]};
            endcase
            check_eq(it.tag, obs, it.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [2:0] model_y(input logic [9:0] s);
        logic [2:0] r;
        r = 3'd0;
        if (s[8]) begin
            for (int i = 7; i >= 0; i--) begin
                if (s[i]) begin
                    r = 3'(i);
                    break;
                end
            end
        end
        return r;
    endfunction

    initial begin
        logic [7:0]  enc_in [5];
        logic [2:0]  enc_exp [5];
        logic [3:0]  nib;
        logic [2:0]  ym;

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        sw    = 10'h000;

        // Reset value, first rotation, full wrap-around
        tick(1);
        sb_push("rst_light", K_LIGHT, 16'h001);
        sb_drain();
        rst = 1'b0;
        tick(3);
        sb_push("pre_step1", K_LIGHT, 16'h001);
        sb_drain();
        tick(1);
        sb_push("step1", K_LIGHT, 16'h002);
        sb_drain();
        tick(40);
        sb_push("step11", K_LIGHT, 16'h800);
        sb_drain();
        tick(4);
        sb_push("wrap", K_LIGHT, 16'h001);
        sb_drain();

        // Mid-count reset
        tick(18);
        sb_push("lr_010", K_LIGHT, 16'h010);
        sb_drain();
        rst = 1'b1;
        #1;
        sb_push("async_rst", K_LIGHT, 16'h001);
        sb_drain();
        rst = 1'b0;
        tick(3);
        sb_push("post_rst_hold", K_LIGHT, 16'h001);
        sb_drain();
        tick(1);
        sb_push("post_rst_step", K_LIGHT, 16'h002);
        sb_drain();

        // Priority encoder
        enc_in  = '{8'h01, 8'h02, 8'h80, 8'hA5, 8'h00};
        enc_exp = '{3'd0, 3'd1, 3'd7, 3'd7, 3'd0};
        for (int i = 0; i < 5; i++) begin
            sw = {2'b01, enc_in[i]};
            #1;
            sb_push($sformatf("enc_%h", enc_in[i]), K_Y, {13'h0, enc_exp[i]});
            sb_drain();
        end
        sw = {2'b00, 8'h80};
        #1;
        sb_push("enc_disabled", K_Y, 16'h0);
        sb_drain();

        // Display of y = 0..7, then blanking
        for (int i = 0; i < 8; i++) begin
            sw = {2'b11, 8'(1 << i)};
            #1;
            sb_push($sformatf("hex_y%0d", i), K_HEX, {8'h0, HEX_TAB[i]});
            sb_drain();
        end
        sw[9] = 1'b0;
        #1;
        sb_push("hex_blank", K_HEX, 16'h00FF);
        sb_drain();

        // Decoder nibbles outside the encoder's reach
        for (int i = 8; i < 16; i++) begin
            nib = 4'(i);
            check_eq($sformatf("dec_%h", nib), {8'h0, seg7_decode(nib)}, {8'h0, HEX_TAB[i]});
        end

        // Random switches alongside a running light
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            sw = 10'($urandom);
            #1;
            ym = model_y(sw);
            sb_push("rnd_y", K_Y, {13'h0, ym});
            sb_push("rnd_hex", K_HEX, {8'h0, (sw[9] ? HEX_TAB[{1'b0, ym}] : 8'hFF)});
            sb_push("rnd_onehot", K_ONEHOT, 16'd1);
            sb_push("rnd_led3", K_LED3, 16'd0);
            sb_push("rnd_dp", K_DP, 16'd1);
            sb_drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
